// File: rtl/cu_scheduler.sv
// cu_scheduler: sequences chunk-pair loads into a compute unit, captures the
// running partial sum it returns, and writes one finished sum per output into
// the output buffer.
//
// Optional feature: define CU_SCHED_PSUM_LOAD_EN to preload each output's
// partial sum from the output buffer (FETCH/FETCH_WAIT) before its first
// chunk, so a job accumulates on top of an earlier pass. Without the macro
// every output starts at zero and the buffer is never read.
//
// Reset is synchronous and active-low (rst_i == 0 at a rising edge).
// All control outputs are decoded from the registered state, so they read 0
// the cycle after reset. The write strobe and done pulse are also masked by
// abort_i, so an aborted cycle never writes or signals completion.

module cu_scheduler #(
  parameter int CHUNK_CNT_W     = 8,
  parameter int OUT_ADDR_W      = 6,
  parameter int OUTPUT_BUF_SIZE = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [CHUNK_CNT_W-1:0]     num_chunks_i,
  input  logic [OUT_ADDR_W:0]        num_outputs_i,
  input  logic                       abort_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic                       src_req_o,
  output logic [CHUNK_CNT_W-1:0]     src_chunk_idx_o,
  output logic [OUT_ADDR_W-1:0]      src_out_idx_o,
  input  logic                       src_ack_i,
  input  logic                       cu_acc_val_i,
  input  logic [OUTPUT_BUF_SIZE-1:0] cu_acc_dat_i,
  output logic [OUTPUT_BUF_SIZE-1:0] cu_acc_dat_o,
  output logic                       obuf_rd_en_o,
  input  logic [OUTPUT_BUF_SIZE-1:0] obuf_rd_dat_i,
  output logic                       obuf_wr_en_o,
  output logic [OUT_ADDR_W-1:0]      obuf_addr_o,
  output logic [OUTPUT_BUF_SIZE-1:0] obuf_wr_dat_o
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH      = 3'd1,
    S_FETCH_WAIT = 3'd2,
    S_LOAD       = 3'd3,
    S_COMPUTE    = 3'd4,
    S_WRITEBACK  = 3'd5,
    S_DONE       = 3'd6
  } state_t;

  localparam logic [CHUNK_CNT_W-1:0] CHUNK_ONE   = CHUNK_CNT_W'(1);
  localparam logic [OUT_ADDR_W-1:0]  OUT_IDX_ONE = OUT_ADDR_W'(1);
  localparam logic [OUT_ADDR_W:0]    OUT_CNT_ONE = (OUT_ADDR_W + 1)'(1);

`ifdef CU_SCHED_PSUM_LOAD_EN
  // Every output begins by fetching its previous partial sum.
  localparam state_t FIRST_STATE = S_FETCH;
`else
  // Every output begins directly with its first chunk load, psum at zero.
  localparam state_t FIRST_STATE = S_LOAD;
  // The read data port only exists for the preload path.
  logic unused_rd_dat;
  assign unused_rd_dat = ^obuf_rd_dat_i;
`endif

  state_t                       state_reg, state_next;
  logic [CHUNK_CNT_W-1:0]       num_chunks_reg, num_chunks_next;
  logic [OUT_ADDR_W:0]          num_outputs_reg, num_outputs_next;
  logic [CHUNK_CNT_W-1:0]       chunk_cnt_reg, chunk_cnt_next;
  logic [OUT_ADDR_W-1:0]        out_idx_reg, out_idx_next;
  logic [OUTPUT_BUF_SIZE-1:0]   psum_reg, psum_next;
  logic                         err_reg, err_next;

  logic                         job_empty;
  logic                         last_chunk;
  logic                         last_output;
  logic                         illegal_acc;
  logic                         illegal_ack;

  // A zero count in either dimension means there is nothing to schedule.
  assign job_empty   = (num_chunks_i == '0) || (num_outputs_i == '0);
  // Counts are latched non-zero for any real job, so the minus-one never wraps.
  assign last_chunk  = (chunk_cnt_reg == (num_chunks_reg - CHUNK_ONE));
  assign last_output = ({1'b0, out_idx_reg} == (num_outputs_reg - OUT_CNT_ONE));
  // Handshake events arriving in the wrong state are protocol errors.
  assign illegal_acc = cu_acc_val_i && (state_reg != S_COMPUTE);
  assign illegal_ack = src_ack_i && (state_reg != S_LOAD);

  // Datapath outputs are straight register taps and stay stable between updates.
  assign src_chunk_idx_o = chunk_cnt_reg;
  assign src_out_idx_o   = out_idx_reg;
  assign cu_acc_dat_o    = psum_reg;
  assign obuf_addr_o     = out_idx_reg;
  assign obuf_wr_dat_o   = psum_reg;
  assign err_o           = err_reg;

  // Next-state, counter and partial-sum update plus state-decoded strobes.
  always_comb begin
    state_next       = state_reg;
    num_chunks_next  = num_chunks_reg;
    num_outputs_next = num_outputs_reg;
    chunk_cnt_next   = chunk_cnt_reg;
    out_idx_next     = out_idx_reg;
    psum_next        = psum_reg;
    err_next         = err_reg;
    busy_o           = (state_reg != S_IDLE);
    done_o           = 1'b0;
    src_req_o        = 1'b0;
    obuf_rd_en_o     = 1'b0;
    obuf_wr_en_o     = 1'b0;

    // Out-of-state events only raise the sticky flag; they change nothing else.
    if (illegal_acc || illegal_ack) begin
      err_next = 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        if (start_i) begin
          num_chunks_next  = num_chunks_i;
          num_outputs_next = num_outputs_i;
          chunk_cnt_next   = '0;
          out_idx_next     = '0;
          psum_next        = '0;
          err_next         = 1'b0;
          state_next       = job_empty ? S_DONE : FIRST_STATE;
        end
      end

`ifdef CU_SCHED_PSUM_LOAD_EN
      S_FETCH: begin
        obuf_rd_en_o = 1'b1;
        state_next   = S_FETCH_WAIT;
      end

      S_FETCH_WAIT: begin
        // Buffer read data arrives one cycle after the read strobe.
        psum_next  = obuf_rd_dat_i;
        state_next = S_LOAD;
      end
`endif

      S_LOAD: begin
        src_req_o = 1'b1;
        if (src_ack_i) begin
          state_next = S_COMPUTE;
        end
      end

      S_COMPUTE: begin
        if (cu_acc_val_i) begin
          // The compute unit returns the full running sum; store it as-is.
          psum_next = cu_acc_dat_i;
          if (last_chunk) begin
            state_next = S_WRITEBACK;
          end else begin
            chunk_cnt_next = chunk_cnt_reg + CHUNK_ONE;
            state_next     = S_LOAD;
          end
        end
      end

      S_WRITEBACK: begin
        obuf_wr_en_o = !abort_i;
        if (last_output) begin
          state_next = S_DONE;
        end else begin
          out_idx_next   = out_idx_reg + OUT_IDX_ONE;
          chunk_cnt_next = '0;
          psum_next      = '0;
          state_next     = FIRST_STATE;
        end
      end

      S_DONE: begin
        done_o     = !abort_i;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Abort wins over everything else that happened this cycle.
    if (abort_i && (state_reg != S_IDLE)) begin
      state_next       = S_IDLE;
      num_chunks_next  = num_chunks_reg;
      num_outputs_next = num_outputs_reg;
      chunk_cnt_next   = chunk_cnt_reg;
      out_idx_next     = out_idx_reg;
      psum_next        = psum_reg;
      err_next         = err_reg;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg       <= S_IDLE;
      num_chunks_reg  <= '0;
      num_outputs_reg <= '0;
      chunk_cnt_reg   <= '0;
      out_idx_reg     <= '0;
      psum_reg        <= '0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      num_chunks_reg  <= num_chunks_next;
      num_outputs_reg <= num_outputs_next;
      chunk_cnt_reg   <= chunk_cnt_next;
      out_idx_reg     <= out_idx_next;
      psum_reg        <= psum_next;
      err_reg         <= err_next;
    end
  end

endmodule

// File: tb/tb_cu_scheduler.sv
// tb_cu_scheduler: directed scenarios for cu_scheduler with a small output
// buffer model (registered read, write log) and hand-computed expectations.
// The preload scenario is compiled in only when CU_SCHED_PSUM_LOAD_EN is set.

module tb_cu_scheduler;

  localparam int CW = 8;
  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk;
  logic          rst_i;
  logic          start_i;
  logic [CW-1:0] num_chunks_i;
  logic [AW:0]   num_outputs_i;
  logic          abort_i;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic          src_req_o;
  logic [CW-1:0] src_chunk_idx_o;
  logic [AW-1:0] src_out_idx_o;
  logic          src_ack_i;
  logic          cu_acc_val_i;
  logic [DW-1:0] cu_acc_dat_i;
  logic [DW-1:0] cu_acc_dat_o;
  logic          obuf_rd_en_o;
  logic [DW-1:0] obuf_rd_dat;
  logic          obuf_wr_en_o;
  logic [AW-1:0] obuf_addr_o;
  logic [DW-1:0] obuf_wr_dat_o;

  cu_scheduler #(
    .CHUNK_CNT_W(CW),
    .OUT_ADDR_W(AW),
    .OUTPUT_BUF_SIZE(DW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .start_i(start_i),
    .num_chunks_i(num_chunks_i),
    .num_outputs_i(num_outputs_i),
    .abort_i(abort_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o),
    .src_req_o(src_req_o),
    .src_chunk_idx_o(src_chunk_idx_o),
    .src_out_idx_o(src_out_idx_o),
    .src_ack_i(src_ack_i),
    .cu_acc_val_i(cu_acc_val_i),
    .cu_acc_dat_i(cu_acc_dat_i),
    .cu_acc_dat_o(cu_acc_dat_o),
    .obuf_rd_en_o(obuf_rd_en_o),
    .obuf_rd_dat_i(obuf_rd_dat),
    .obuf_wr_en_o(obuf_wr_en_o),
    .obuf_addr_o(obuf_addr_o),
    .obuf_wr_dat_o(obuf_wr_dat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Output buffer model and event log, all owned by one process.
  logic [DW-1:0] mem [0:63];
  logic          poke_en   = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [DW-1:0] poke_val  = '0;
  int            cyc       = 0;
  int            wr_cnt    = 0;
  int            done_cnt  = 0;
  int            done_cyc  = 0;
  int            req_cnt   = 0;
  logic [AW-1:0] wr_addr_log [0:31];
  logic [DW-1:0] wr_dat_log  [0:31];
  int            wr_cyc_log  [0:31];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (obuf_rd_en_o === 1'b1) obuf_rd_dat <= mem[obuf_addr_o];
    if (obuf_wr_en_o === 1'b1) begin
      mem[obuf_addr_o] <= obuf_wr_dat_o;
      if (wr_cnt < 32) begin
        wr_addr_log[wr_cnt] <= obuf_addr_o;
        wr_dat_log[wr_cnt]  <= obuf_wr_dat_o;
        wr_cyc_log[wr_cnt]  <= cyc;
      end
      wr_cnt <= wr_cnt + 1;
    end else if (poke_en) begin
      mem[poke_addr] <= poke_val;
    end
    if (done_o === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (src_req_o === 1'b1) req_cnt <= req_cnt + 1;
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic start_job(input int nc, input int no);
    start_i       = 1'b1;
    num_chunks_i  = CW'(nc);
    num_outputs_i = (AW + 1)'(no);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Acknowledge the pending load, then return one accumulated value.
  task automatic do_chunk(input logic [DW-1:0] acc);
    src_ack_i = 1'b1;
    @(negedge clk);
    src_ack_i    = 1'b0;
    cu_acc_val_i = 1'b1;
    cu_acc_dat_i = acc;
    @(negedge clk);
    cu_acc_val_i = 1'b0;
  endtask

  task automatic wait_src_req(input string tag);
    int n = 0;
    while (src_req_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (src_req_o !== 1'b1) begin
      bad++;
      $display("FAIL %s req_timeout: src_req_o=%b want 1", tag, src_req_o);
    end
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (done_cnt != d0 + 1) begin
      bad++;
      $display("FAIL %s done_timeout: done pulses=%0d want 1", tag, done_cnt - d0);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_o); end
    total++; if (src_req_o !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", src_req_o); end
    total++; if (obuf_wr_en_o !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %b want 0", obuf_wr_en_o); end
    total++; if (obuf_rd_en_o !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", obuf_rd_en_o); end
    total++; if (cu_acc_dat_o !== '0) begin bad++; $display("FAIL reset_psum: got %0d want 0", cu_acc_dat_o); end
    rst_i = 1'b1;
    @(negedge clk);
    $display("reset: busy=%b err=%b", busy_o, err_o);
  endtask

  // 3 chunks x 2 outputs, immediate acks: writes (0,14) then (1,6).
  task automatic test_basic();
    logic [DW-1:0] vals [6] = '{32'd5, 32'd9, 32'd14, 32'd2, 32'd4, 32'd6};
    int wr0 = wr_cnt;
    int d0  = done_cnt;
    start_job(3, 2);
    for (int o = 0; o < 2; o++) begin
      for (int c = 0; c < 3; c++) begin
        wait_src_req("basic");
        total++;
        if (src_chunk_idx_o !== CW'(c) || src_out_idx_o !== AW'(o)) begin
          bad++;
          $display("FAIL basic_idx: chunk=%0d out=%0d want chunk=%0d out=%0d",
                   src_chunk_idx_o, src_out_idx_o, c, o);
        end
        do_chunk(vals[o*3+c]);
        total++;
        if (cu_acc_dat_o !== vals[o*3+c]) begin
          bad++;
          $display("FAIL basic_psum: got %0d want %0d", cu_acc_dat_o, vals[o*3+c]);
        end
      end
    end
    wait_done("basic", d0);
    total++;
    if (wr_cnt - wr0 != 2) begin
      bad++; $display("FAIL basic_wr_count: got %0d want 2", wr_cnt - wr0);
    end else begin
      total++;
      if (wr_addr_log[wr0] !== 6'd0 || wr_dat_log[wr0] !== 32'd14) begin
        bad++; $display("FAIL basic_wr0: got (%0d,%0d) want (0,14)", wr_addr_log[wr0], wr_dat_log[wr0]);
      end
      total++;
      if (wr_addr_log[wr0+1] !== 6'd1 || wr_dat_log[wr0+1] !== 32'd6) begin
        bad++; $display("FAIL basic_wr1: got (%0d,%0d) want (1,6)", wr_addr_log[wr0+1], wr_dat_log[wr0+1]);
      end
      total++;
      if (done_cyc != wr_cyc_log[wr0+1] + 1) begin
        bad++; $display("FAIL basic_done_timing: done at %0d want %0d", done_cyc, wr_cyc_log[wr0+1] + 1);
      end
    end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", busy_o); end
    $display("basic: writes=%0d done_cyc=%0d", wr_cnt - wr0, done_cyc);
  endtask

  // Ack held off 4 cycles: request and indices stay put for 5 cycles.
  // A start_i pulse mid-job with different counts must be ignored.
  task automatic test_ack_delay();
    int wr0 = wr_cnt;
    int d0  = done_cnt;
    start_job(1, 1);
    wait_src_req("ack_delay");
    for (int i = 0; i < 4; i++) begin
      total++;
      if (src_req_o !== 1'b1 || src_chunk_idx_o !== '0 || src_out_idx_o !== '0) begin
        bad++;
        $display("FAIL ack_delay_hold%0d: req=%b chunk=%0d out=%0d want 1/0/0",
                 i, src_req_o, src_chunk_idx_o, src_out_idx_o);
      end
      if (i == 1) begin
        start_i = 1'b1; num_chunks_i = 8'd9; num_outputs_i = 7'd5;
      end
      if (i == 2) start_i = 1'b0;
      @(negedge clk);
    end
    total++;
    if (src_req_o !== 1'b1) begin bad++; $display("FAIL ack_delay_cycle5: req=%b want 1", src_req_o); end
    src_ack_i = 1'b1;
    @(negedge clk);
    src_ack_i = 1'b0;
    total++;
    if (src_req_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++; $display("FAIL ack_delay_compute: req=%b busy=%b want 0/1", src_req_o, busy_o);
    end
    cu_acc_val_i = 1'b1; cu_acc_dat_i = 32'd3;
    @(negedge clk);
    cu_acc_val_i = 1'b0;
    wait_done("ack_delay", d0);
    total++;
    if (wr_cnt - wr0 != 1 || wr_addr_log[wr0] !== 6'd0 || wr_dat_log[wr0] !== 32'd3) begin
      bad++; $display("FAIL ack_delay_write: count=%0d data=%0d want 1 write of 3", wr_cnt - wr0, wr_dat_log[wr0]);
    end
    $display("ack_delay: writes=%0d", wr_cnt - wr0);
  endtask

  // Abort in COMPUTE of chunk 1, together with an acc pulse that must lose.
  task automatic test_abort();
    int wr0 = wr_cnt;
    int d0  = done_cnt;
    start_job(3, 2);
    wait_src_req("abort");
    do_chunk(32'd5);
    wait_src_req("abort");
    total++;
    if (src_chunk_idx_o !== 8'd1) begin bad++; $display("FAIL abort_chunk_idx: got %0d want 1", src_chunk_idx_o); end
    src_ack_i = 1'b1;
    @(negedge clk);
    src_ack_i    = 1'b0;
    abort_i      = 1'b1;
    cu_acc_val_i = 1'b1;
    cu_acc_dat_i = 32'd999;
    @(negedge clk);
    abort_i      = 1'b0;
    cu_acc_val_i = 1'b0;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy_o); end
    total++; if (cu_acc_dat_o !== 32'd5) begin bad++; $display("FAIL abort_psum: got %0d want 5", cu_acc_dat_o); end
    repeat (5) @(negedge clk);
    total++; if (src_req_o !== 1'b0) begin bad++; $display("FAIL abort_req: got %b want 0", src_req_o); end
    total++; if (wr_cnt != wr0) begin bad++; $display("FAIL abort_write: got %0d writes want 0", wr_cnt - wr0); end
    total++; if (done_cnt != d0) begin bad++; $display("FAIL abort_done: got %0d pulses want 0", done_cnt - d0); end
    $display("abort: busy=%b writes=%0d", busy_o, wr_cnt - wr0);
  endtask

  // Acc pulse in LOAD is a protocol error: sticky, state and psum untouched.
  task automatic test_err();
    int wr0 = wr_cnt;
    int d0  = done_cnt;
    start_job(2, 1);
    wait_src_req("err");
    cu_acc_val_i = 1'b1; cu_acc_dat_i = 32'd77;
    @(negedge clk);
    cu_acc_val_i = 1'b0;
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", err_o); end
    total++; if (src_req_o !== 1'b1) begin bad++; $display("FAIL err_state: req=%b want 1", src_req_o); end
    total++; if (cu_acc_dat_o !== 32'd0) begin bad++; $display("FAIL err_psum: got %0d want 0", cu_acc_dat_o); end
    repeat (2) @(negedge clk);
    do_chunk(32'd10);
    wait_src_req("err");
    do_chunk(32'd20);
    wait_done("err", d0);
    total++;
    if (wr_cnt - wr0 != 1 || wr_dat_log[wr0] !== 32'd20) begin
      bad++; $display("FAIL err_job_write: count=%0d data=%0d want 1 write of 20", wr_cnt - wr0, wr_dat_log[wr0]);
    end
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err_o); end
    // Empty start (zero chunks) clears the flag.
    start_job(0, 3);
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", err_o); end
    @(negedge clk);
    // Ack while idle is also illegal.
    src_ack_i = 1'b1;
    @(negedge clk);
    src_ack_i = 1'b0;
    total++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      bad++; $display("FAIL err_idle_ack: err=%b busy=%b want 1/0", err_o, busy_o);
    end
    $display("err: err_o=%b", err_o);
  endtask

  // Zero outputs: DONE right after the start cycle, no requests or writes.
  task automatic test_empty();
    int wr0 = wr_cnt;
    int r0  = req_cnt;
    start_job(4, 0);
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL empty_done: got %b want 1", done_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL empty_err_clear: got %b want 0", err_o); end
    @(negedge clk);
    total++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL empty_end: done=%b busy=%b want 0/0", done_o, busy_o);
    end
    total++; if (req_cnt != r0 || wr_cnt != wr0) begin
      bad++; $display("FAIL empty_activity: req=%0d wr=%0d want 0/0", req_cnt - r0, wr_cnt - wr0);
    end
    $display("empty: done seen, requests=%0d", req_cnt - r0);
  endtask

  // Reset in the middle of a job drops it without writing.
  task automatic test_reset_mid_job();
    int wr0 = wr_cnt;
    start_job(2, 1);
    wait_src_req("rst_mid");
    do_chunk(32'd4);
    wait_src_req("rst_mid");
    rst_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    total++; if (busy_o !== 1'b0 || src_req_o !== 1'b0) begin
      bad++; $display("FAIL rst_mid_state: busy=%b req=%b want 0/0", busy_o, src_req_o);
    end
    total++; if (cu_acc_dat_o !== 32'd0) begin bad++; $display("FAIL rst_mid_psum: got %0d want 0", cu_acc_dat_o); end
    repeat (3) @(negedge clk);
    total++; if (wr_cnt != wr0) begin bad++; $display("FAIL rst_mid_write: got %0d writes want 0", wr_cnt - wr0); end
    $display("reset_mid_job: busy=%b", busy_o);
  endtask

`ifdef CU_SCHED_PSUM_LOAD_EN
  // obuf[0]=100 preloaded, one chunk returns 107.
  task automatic test_psum_preload();
    int wr0 = wr_cnt;
    int d0  = done_cnt;
    poke_en = 1'b1; poke_addr = '0; poke_val = 32'd100;
    @(negedge clk);
    poke_en = 1'b0;
    start_job(1, 1);
    total++; if (obuf_rd_en_o !== 1'b1 || obuf_addr_o !== 6'd0) begin
      bad++; $display("FAIL preload_rd: rd_en=%b addr=%0d want 1/0", obuf_rd_en_o, obuf_addr_o);
    end
    wait_src_req("preload");
    total++; if (cu_acc_dat_o !== 32'd100) begin bad++; $display("FAIL preload_psum: got %0d want 100", cu_acc_dat_o); end
    do_chunk(32'd107);
    wait_done("preload", d0);
    total++;
    if (wr_cnt - wr0 != 1 || wr_addr_log[wr0] !== 6'd0 || wr_dat_log[wr0] !== 32'd107) begin
      bad++; $display("FAIL preload_write: count=%0d data=%0d want 1 write of 107", wr_cnt - wr0, wr_dat_log[wr0]);
    end
    $display("psum_preload: writes=%0d", wr_cnt - wr0);
  endtask
`endif

  initial begin
    rst_i         = 1'b0;
    start_i       = 1'b0;
    num_chunks_i  = '0;
    num_outputs_i = '0;
    abort_i       = 1'b0;
    src_ack_i     = 1'b0;
    cu_acc_val_i  = 1'b0;
    cu_acc_dat_i  = '0;
    test_reset();
    test_basic();
    test_ack_delay();
    test_abort();
    test_err();
    test_empty();
    test_reset_mid_job();
`ifdef CU_SCHED_PSUM_LOAD_EN
    test_psum_preload();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case a scenario wedges despite its bounded waits.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
